// File: rtl/aes_pkg.sv
// Shared AES control definitions: FSM states, widths and the GF(2^8) xtime helper.
// Used by aes_round_ctrl and the MixColumns datapath.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_NR    = 10;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_st_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round counter and round-constant register for the AES round controller.
// load starts round 1 with RCON_INIT; step advances both by one round.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [3:0] rnd,
  output logic [7:0] rcon,
  output logic       last
);

  logic [3:0] rnd_q, rnd_d;
  logic [7:0] rcon_q, rcon_d;

  always_comb begin
    rnd_d  = rnd_q;
    rcon_d = rcon_q;
    if (load) begin
      rnd_d  = 4'd1;
      rcon_d = RCON_INIT;
    end else if (step) begin
      rnd_d  = rnd_q + 4'd1;
      rcon_d = xtime(rcon_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q  <= 4'd0;
      rcon_q <= RCON_INIT;
    end else begin
      rnd_q  <= rnd_d;
      rcon_q <= rcon_d;
    end
  end

  assign rnd  = rnd_q;
  assign rcon = rcon_q;
  assign last = (rnd_q == 4'(AES_NR));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: holds state/key registers, drives the external round datapath.
// Optional abort input enabled by defining AES_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:AES_BLK_W-1] pt_in,
  input  logic [0:AES_BLK_W-1] key_in,
  output logic [0:AES_BLK_W-1] rnd_state,
  output logic [0:AES_BLK_W-1] rnd_key,
  output logic [7:0]           rnd_rcon,
  output logic                 rnd_last,
  input  logic [0:AES_BLK_W-1] rnd_result,
  input  logic [0:AES_BLK_W-1] rnd_next_key,
  output logic [0:AES_BLK_W-1] ct_out,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef AES_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  aes_st_e fsm_q, fsm_d;

  logic [0:AES_BLK_W-1] st_q, st_d;
  logic [0:AES_BLK_W-1] key_q, key_d;

  logic       load, step, clr;
  logic [3:0] rnd;
  logic       last;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    key_d = key_q;
    load  = 1'b0;
    step  = 1'b0;
    clr   = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d  = pt_in ^ key_in;
          key_d = key_in;
          load  = 1'b1;
          fsm_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        st_d  = rnd_result;
        key_d = rnd_next_key;
        step  = 1'b1;
        if (rnd == 4'(AES_NR)) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
`ifdef AES_ABORT_EN
    // Abort drops the block entirely; the next accept starts from a clean slate.
    if (abort && fsm_q != ST_IDLE) begin
      fsm_d = ST_IDLE;
      st_d  = '0;
      key_d = '0;
      load  = 1'b0;
      step  = 1'b0;
      clr   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
      st_q  <= '0;
      key_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      key_q <= key_d;
    end
  end

  aes_rcon_gen u_rcon (
    .clk  (clk),
    .rst  (rst | clr),
    .load (load),
    .step (step),
    .rnd  (rnd),
    .rcon (rnd_rcon),
    .last (last)
  );

  // Handshake outputs are forced low for as long as reset is held.
  assign in_ready  = !rst && (fsm_q == ST_IDLE);
  assign out_valid = !rst && (fsm_q == ST_DONE);
  assign rnd_last  = !rst && (fsm_q == ST_ROUND) && last;
  assign ct_out    = rst ? '0 : st_q;
  assign rnd_state = st_q;
  assign rnd_key   = key_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round model.
// Define AES_ABORT_EN to also exercise the abort input.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [0:127] pt_in, key_in, rnd_state, rnd_key, rnd_result, rnd_next_key, ct_out;
  logic [7:0]   rnd_rcon;
  logic         rnd_last;
`ifdef AES_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pt_in        (pt_in),
    .key_in       (key_in),
    .rnd_state    (rnd_state),
    .rnd_key      (rnd_key),
    .rnd_rcon     (rnd_rcon),
    .rnd_last     (rnd_last),
    .rnd_result   (rnd_result),
    .rnd_next_key (rnd_next_key),
    .ct_out       (ct_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
`ifdef AES_ABORT_EN
    ,
    .abort        (abort)
`endif
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gm(r, b);
    return r ^ rol(r, 1) ^ rol(r, 2) ^ rol(r, 3) ^ rol(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:127] kexp(input logic [0:127] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[0+:32];
    w1 = k[32+:32];
    w2 = k[64+:32];
    w3 = k[96+:32];
    t  = {sb(w3[23:16]) ^ rc, sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [0:127] rnd_f(input logic [0:127] s, input logic [0:127] k,
                                         input logic lst);
    logic [7:0]   b[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] o;
    for (int i = 0; i < 16; i++) b[i] = sb(s[8*i+:8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (!lst) begin
        t[4*c]   = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
        t[4*c+3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
      end
    end
    for (int i = 0; i < 16; i++) o[8*i+:8] = t[i] ^ k[8*i+:8];
    return o;
  endfunction

  always_comb begin
    rnd_next_key = kexp(rnd_key, rnd_rcon);
    rnd_result   = rnd_f(rnd_state, rnd_next_key, rnd_last);
  end

  localparam logic [0:127] KA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one block, track every round, optionally stall in DONE, then release.
  task automatic run_block(input logic [0:127] p, input logic [0:127] kk,
                           input logic [0:127] e, input int hold);
    logic [7:0] rc_tab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    pt_in = p; key_in = kk; in_valid = 1'b1; out_ready = (hold == 0);
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int r = 0; r < 10; r++) begin
      chk("rcon", rnd_rcon, rc_tab[r]);
      chk("rnd_last", rnd_last, (r == 9));
      chk("out_valid_busy", out_valid, 0);
      chk("in_ready_busy", in_ready, 0);
      step();
    end
    chk("out_valid_cycle11", out_valid, 1);
    chk("ct_out", ct_out, e);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_ct_out", ct_out, e);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    int acc[$];
    logic [0:127] cts[$];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt_in = '0; key_in = '0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rnd_last", rnd_last, 0);
    chk("rst_ct_out", ct_out, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_block(PA, KA, CA, 5);
    run_block(PB, KB, CB, 0);

    pt_in = PA; key_in = KA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("mid_rcon_r5", rnd_rcon, 8'h10);
    rst = 1'b1;
    step();
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_ct_out", ct_out, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", in_ready, 1);
    chk("mid_post_out_valid", out_valid, 0);
    run_block(PB, KB, CB, 0);

    pt_in = PA; key_in = KA; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready) acc.push_back(cyc);
      if (out_valid) cts.push_back(ct_out);
      step();
      if (acc.size() == 1) begin
        pt_in = PB; key_in = KB;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(acc.size() >= 2), 1);
    chk("b2b_spacing", 128'((acc.size() >= 2) ? acc[1] - acc[0] : -1), 12);
    chk("b2b_outputs", 128'(cts.size() >= 2), 1);
    chk("b2b_ct0", (cts.size() >= 1) ? cts[0] : '0, CA);
    chk("b2b_ct1", (cts.size() >= 2) ? cts[1] : '0, CB);

    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
`ifdef AES_ABORT_EN
    pt_in = PB; key_in = KB; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_rcon_r3", rnd_rcon, 8'h04);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    run_block(PA, KA, CA, 0);
`endif
    run_block(PA, KA, CA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have ports in this order: clk  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have in_valid  in  1  and in_ready  out  1  as the block-input handshake.
REQ-004 SHALL have pt_in  in  128 [0:127], the plaintext, and key_in  in  128 [0:127], the cipher key; byte 0 is bits [0:7].
REQ-005 SHALL have rnd_state  out  128 and rnd_key  out  128, the registered state and previous round key driven to the round datapath.
REQ-006 SHALL have rnd_rcon  out  8  (round constant) and rnd_last  out  1  (high in round 10, meaning MixColumns is bypassed).
REQ-007 SHALL have rnd_result  in  128 and rnd_next_key  in  128, the combinational datapath returns for the current round.
REQ-008 SHALL have ct_out  out  128, out_valid  out  1 and out_ready  in  1.
REQ-009 SHALL have, only when AES_ABORT_EN is defined, abort  in  1.

Function
REQ-010 SHALL implement FSM states IDLE, ROUND, DONE.
REQ-011 SHALL drive in_ready=1 only in IDLE.
REQ-012 SHALL, on an IDLE edge with in_valid=1: load state to pt_in^key_in and key to key_in, set rnd to 1 and rcon to 8'h01, and go to ROUND.
REQ-013 SHALL, on every ROUND edge: load state from rnd_result and key from rnd_next_key, increment rnd, and advance rcon by xtime (GF(2^8) multiply by 2, reducing with 8'h1b).
REQ-014 SHALL go to DONE on the ROUND edge where rnd==10; rnd_last=1 exactly when in ROUND with rnd==10.
REQ-015 SHALL produce rcon values 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-016 SHALL assert out_valid only in DONE, 11 cycles after the accept edge; ct_out equals the state register.
REQ-017 SHALL hold ct_out and out_valid stable while out_ready=0.
REQ-018 SHALL, on a DONE edge with out_ready=1, return to IDLE; in_ready rises the next cycle, giving a minimum spacing of 12 cycles between accepts.
REQ-019 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-020 SHALL drive rnd_state and rnd_key directly from the registers; their value in IDLE and DONE is don't-care to the datapath.

Reset
REQ-021 SHALL, on rst=1 at any edge and in any state including mid-round, go to IDLE with rnd=0, rcon=8'h01, state=0, key=0.
REQ-022 SHALL hold outputs while in reset at: in_ready=0, out_valid=0, rnd_last=0, ct_out=0; in_ready=1 on the first cycle after rst deasserts.
REQ-023 SHALL have rst take priority over every other input, including abort.

Configuration
REQ-024 SHALL, with AES_ABORT_EN defined, go to IDLE on an edge where abort=1 in ROUND or DONE, clearing state, key and rnd; out_valid=0 and in_ready=1 the next cycle. Abort in IDLE has no effect.
REQ-025 SHALL, without AES_ABORT_EN, have no abort port and keep all other behaviour identical.

Structure
REQ-026 SHALL take from shared package aes_pkg: the FSM state enum, AES_BLK_W=128, AES_NR=10, RCON_INIT=8'h01, RCON_POLY=8'h1b, and an xtime function shared with the MixColumns datapath.
REQ-027 SHALL put the rnd counter and rcon register in one sub-module, aes_rcon_gen (inputs: clk, rst, load, step; outputs: rnd, rcon, last); the rest stays flat.
REQ-028 SHALL leave SubBytes, ShiftRows, MixColumns and key expansion outside this block; the bench connects a reference round model.

Verification
REQ-029 SHALL cover a FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
REQ-030 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> ct_out and out_valid stable, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-031 SHALL cover rcon and rnd_last tracking: rnd_rcon sequence 01..36 per REQ-015, and rnd_last=1 only in the 10th ROUND cycle.
REQ-032 SHALL cover reset mid-operation: rst pulsed at round 5 -> next cycle in_ready=1, out_valid=0; a following block encrypts correctly.
REQ-033 SHALL cover back-to-back blocks: in_valid held high with out_ready=1 -> accepts 12 cycles apart, both ciphertexts correct, in_valid ignored while busy.
REQ-034 SHALL cover, with AES_ABORT_EN defined, abort at round 3 -> IDLE next cycle, no out_valid pulse, and the next block is correct.
